slatch_bank: RTL and testbench
==============================

Name: slatch_bank

Overview:
- Parametrised successor to the single-bit enable latch with reset gating.
- Holds CHANNELS independent WIDTH-bit registers. Each register has its own load enable and a shared synchronous clear.
- Optional shadow (double-buffered) mode: loads go to a staging register and reach the outputs only on a commit strobe. This is how display and blitter control registers are updated atomically at frame or line boundaries.
- Sits between the register-decode write path and the units that consume the register values.

Parameters:
- WIDTH, 16: bits per channel.
- CHANNELS, 4: number of independent registers, 1..32.
- SHADOW, 1: 0 = direct mode, where a load updates q the next cycle. 1 = double-buffered mode.
- RESET_VAL, 0: value loaded into every active and shadow register on reset. WIDTH bits, same for all channels.

Ports:
- sys_clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ld  in  CHANNELS  per-channel load enable; bit i loads channel i.
- d  in  CHANNELS*WIDTH  load data, flattened; channel i is d[i*WIDTH +: WIDTH].
- commit  in  1  transfers pending shadows to active. Ignored when SHADOW=0.
- abort  in  1  discards all pending shadows without transfer. Ignored when SHADOW=0.
- q  out  CHANNELS*WIDTH  active register values, flattened the same way as d.
- pend  out  CHANNELS  bit i set means channel i's shadow holds data not yet committed.
- cmt_done  out  1  one-cycle pulse marking that a commit moved at least one channel.

Behaviour:
- Reset (sampled at a clock edge while reset=1):
  - every active and shadow register = RESET_VAL; pend = 0; cmt_done = 0.
  - Reset overrides ld, commit and abort in the same cycle.
  - Reset mid-sequence discards all pending data. There is no partial commit.
- SHADOW=0:
  - active[i] <= d_i when ld[i]=1, else it holds.
  - q reflects the load one cycle after the edge.
  - pend and cmt_done are held at 0; commit and abort have no effect.
- SHADOW=1, load:
  - ld[i]=1 writes shadow[i] <= d_i and sets pend[i] <= 1.
  - active[i] and q are unchanged.
  - Repeated loads before a commit overwrite the shadow; the last load wins.
- SHADOW=1, commit (commit=1, abort=0):
  - every channel with pend[i]=1 gets active[i] <= shadow[i] and pend[i] <= 0.
  - Channels with pend[i]=0 are untouched.
  - q changes on the edge at which commit is sampled.
- Simultaneous ld[i] and commit:
  - the incoming d_i bypasses the shadow: active[i] <= d_i, shadow[i] <= d_i, pend[i] <= 0.
  - A write coincident with the frame-boundary commit therefore lands in the same frame.
- Abort (abort=1):
  - pend <= 0 for every channel without ld[i] that cycle; active is unchanged.
  - Shadow contents are kept but are now stale.
  - Abort has priority over commit; both high = abort only, no transfer, no cmt_done.
  - ld[i] together with abort: shadow[i] is loaded and pend[i] <= 1. The load survives the abort.
- cmt_done:
  - registered; equals 1 in the cycle after an edge at which commit took effect with at least one channel pending or bypassed.
  - Commit with nothing pending: cmt_done stays 0.
- Outputs are driven only from registers; there is no combinational path from inputs to q, pend or cmt_done.

Decomposition:
- Package slatch_pkg holds:
  - the SHADOW_DIRECT=0 and SHADOW_DOUBLE=1 constants;
  - a localparam helper for flattened slice offsets.
- Sub-module slatch_ch is one channel: active, shadow, pend and its next-state logic.
  - Instantiated CHANNELS times in a generate loop.
  - Each instance outputs a per-channel "transferred" bit.
  - The top level ORs these bits into cmt_done.

Test Plan (WIDTH=8, CHANNELS=4, RESET_VAL=8'h00 unless stated):
1. Reset with ld=4'hF, d=32'hFFFFFFFF and commit=1 held for 2 cycles -> q=0, pend=0, cmt_done=0. Then RESET_VAL=8'hA5 build -> every q byte = A5.
2. SHADOW=0: ld=4'b0010, d byte1=8'h3C for one cycle -> next cycle q=32'h00003C00, pend=0. A later commit has no effect.
3. SHADOW=1: load ch0=11 then ch0=22, then ch2=44 -> pend=4'b0101, q=0. Commit -> q=32'h00440022, pend=0, cmt_done=1 one cycle later for exactly 1 cycle.
4. SHADOW=1: with ch1 pending =55, apply ld[3]=1 (d=77) and commit in the same cycle -> q byte1=55, byte3=77, pend=0, cmt_done pulse.
5. SHADOW=1: pend=4'b0011, then abort+commit together with ld[2] (d=66) -> q unchanged, pend=4'b0100, no cmt_done. The next commit -> q byte2=66 only.
6. Commit with pend=0 -> q unchanged, cmt_done=0. Reset asserted while pend=4'b1111 -> pend=0 and a following commit changes nothing.

Source files
------------

// File: rtl/slatch_pkg.sv
// Shared constants and helpers for the slatch_bank register bank.
package slatch_pkg;

  // Operating modes selected by the SHADOW parameter.
  localparam int SHADOW_DIRECT = 0;
  localparam int SHADOW_DOUBLE = 1;

  // Bit offset of channel ch inside a flattened CHANNELS*WIDTH bus.
  function automatic int slice_off(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/slatch_ch.sv
// One channel of the register bank: active value, optional shadow copy,
// pending flag and the next-state rules for load / commit / abort.
module slatch_ch
  import slatch_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               SHADOW    = SHADOW_DOUBLE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             commit,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             pend,
  output logic             xfer
);

  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] shadow_q;
  logic             pend_q;
  logic             commit_eff;

  // Abort outranks commit; in direct mode neither strobe means anything.
  assign commit_eff = (SHADOW == SHADOW_DOUBLE) && commit && !abort;

  // Flags that this channel moves a value into active on the coming edge.
  always_comb begin
    xfer = 1'b0;
    if (!reset && commit_eff && (ld || pend_q))
      xfer = 1'b1;
  end

  // Active/shadow/pend update; a load coincident with commit bypasses the
  // shadow so the write lands in the same frame as the commit.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      active_q <= RESET_VAL;
      shadow_q <= RESET_VAL;
      pend_q   <= 1'b0;
    end else if (SHADOW == SHADOW_DIRECT) begin
      if (ld)
        active_q <= d;
      pend_q <= 1'b0;
    end else if (ld) begin
      shadow_q <= d;
      if (commit_eff) begin
        active_q <= d;
        pend_q   <= 1'b0;
      end else begin
        pend_q   <= 1'b1;
      end
    end else if (abort) begin
      // Shadow keeps its now-stale contents; only the pending mark is dropped.
      pend_q <= 1'b0;
    end else if (commit_eff && pend_q) begin
      active_q <= shadow_q;
      pend_q   <= 1'b0;
    end
  end

  assign q    = active_q;
  assign pend = pend_q;

endmodule

// File: rtl/slatch_bank.sv
// Bank of CHANNELS independent WIDTH-bit control registers with optional
// double buffering, committed atomically at frame/line boundaries.
module slatch_bank
  import slatch_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               CHANNELS  = 4,
  parameter int               SHADOW    = SHADOW_DOUBLE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       ld,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      commit,
  input  logic                      abort,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       pend,
  output logic                      cmt_done
);

  logic [CHANNELS-1:0] xfer;
  logic                cmt_done_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int OFF = slice_off(i, WIDTH);

    slatch_ch #(
      .WIDTH     (WIDTH),
      .SHADOW    (SHADOW),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .sys_clk (sys_clk),
      .reset   (reset),
      .ld      (ld[i]),
      .d       (d[OFF +: WIDTH]),
      .commit  (commit),
      .abort   (abort),
      .q       (q[OFF +: WIDTH]),
      .pend    (pend[i]),
      .xfer    (xfer[i])
    );
  end

  // One-cycle pulse after any commit that actually moved a channel.
  always_ff @(posedge sys_clk) begin
    if (reset)
      cmt_done_q <= 1'b0;
    else
      cmt_done_q <= |xfer;
  end

  assign cmt_done = cmt_done_q;

endmodule

// File: tb/tb_slatch_bank.sv
// Directed bench for slatch_bank: three builds (double-buffered, direct,
// double-buffered with RESET_VAL=A5) checked every cycle against a model.
module tb_slatch_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [3];
  logic [3:0]  ld_v  [3];
  logic [31:0] d_v   [3];
  logic        cm_v  [3];
  logic        ab_v  [3];
  logic [31:0] q_w   [3];
  logic [3:0]  pend_w[3];
  logic        cd_w  [3];

  int total = 0;
  int bad   = 0;

  slatch_bank #(.WIDTH(8), .CHANNELS(4), .SHADOW(1), .RESET_VAL(8'h00)) u_dbl (
    .sys_clk(clk), .reset(rst_v[0]), .ld(ld_v[0]), .d(d_v[0]), .commit(cm_v[0]),
    .abort(ab_v[0]), .q(q_w[0]), .pend(pend_w[0]), .cmt_done(cd_w[0]));

  slatch_bank #(.WIDTH(8), .CHANNELS(4), .SHADOW(0), .RESET_VAL(8'h00)) u_dir (
    .sys_clk(clk), .reset(rst_v[1]), .ld(ld_v[1]), .d(d_v[1]), .commit(cm_v[1]),
    .abort(ab_v[1]), .q(q_w[1]), .pend(pend_w[1]), .cmt_done(cd_w[1]));

  slatch_bank #(.WIDTH(8), .CHANNELS(4), .SHADOW(1), .RESET_VAL(8'hA5)) u_a5 (
    .sys_clk(clk), .reset(rst_v[2]), .ld(ld_v[2]), .d(d_v[2]), .commit(cm_v[2]),
    .abort(ab_v[2]), .q(q_w[2]), .pend(pend_w[2]), .cmt_done(cd_w[2]));

  // ---------------- behavioural model ----------------
  logic [7:0] m_act [3][4];
  logic [7:0] m_sh  [3][4];
  logic       m_pend[3][4];
  logic       m_cd  [3];
  bit         m_ok  [3] = '{0, 0, 0};

  function automatic bit is_dbl(input int k);
    return k != 1;
  endfunction

  function automatic logic [7:0] rv(input int k);
    return (k == 2) ? 8'hA5 : 8'h00;
  endfunction

  function automatic logic [31:0] mq(input int k);
    logic [31:0] r;
    for (int c = 0; c < 4; c++) r[8*c +: 8] = m_act[k][c];
    return r;
  endfunction

  function automatic logic [3:0] mp(input int k);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = m_pend[k][c];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) begin
        for (int c = 0; c < 4; c++) begin
          m_act[k][c] = rv(k); m_sh[k][c] = rv(k); m_pend[k][c] = 1'b0;
        end
        m_cd[k] = 1'b0;
        m_ok[k] = 1'b1;
      end else begin
        logic go;
        logic [7:0] dc;
        go = is_dbl(k) && cm_v[k] && !ab_v[k];
        m_cd[k] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          dc = d_v[k][8*c +: 8];
          if (!is_dbl(k)) begin
            if (ld_v[k][c]) m_act[k][c] = dc;
            m_pend[k][c] = 1'b0;
          end else begin
            if (go && (ld_v[k][c] || m_pend[k][c])) begin
              m_act[k][c] = ld_v[k][c] ? dc : m_sh[k][c];
              m_cd[k] = 1'b1;
            end
            if (ld_v[k][c]) m_sh[k][c] = dc;
            if (ld_v[k][c])               m_pend[k][c] = !go;
            else if (cm_v[k] || ab_v[k])  m_pend[k][c] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every initialised build against the model.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (m_ok[k]) begin
        chk($sformatf("model_q%0d", k),    q_w[k],          mq(k));
        chk($sformatf("model_pend%0d", k), {28'd0, pend_w[k]}, {28'd0, mp(k)});
        chk($sformatf("model_cd%0d", k),   {31'd0, cd_w[k]},   {31'd0, m_cd[k]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int k, input logic r, input logic [3:0] l,
                     input logic [31:0] dd, input logic c, input logic a);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      rst_v[j] = 1'b0; ld_v[j] = 4'h0; d_v[j] = 32'h0; cm_v[j] = 1'b0; ab_v[j] = 1'b0;
    end
    rst_v[k] = r; ld_v[k] = l; d_v[k] = dd; cm_v[k] = c; ab_v[k] = a;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1: reset overrides load and commit, held two cycles on every build.
    for (int j = 0; j < 3; j++) begin
      rst_v[j] = 1'b1; ld_v[j] = 4'hF; d_v[j] = 32'hFFFF_FFFF; cm_v[j] = 1'b1; ab_v[j] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q",    q_w[0], 32'h0);
    chk("rst_pend", {28'd0, pend_w[0]}, 32'h0);
    chk("rst_cd",   {31'd0, cd_w[0]}, 32'h0);
    chk("rst_q_dir", q_w[1], 32'h0);
    chk("rst_q_a5", q_w[2], 32'hA5A5_A5A5);

    // 2: direct mode loads next cycle, commit is inert.
    cyc(1, 0, 4'b0010, 32'h0000_3C00, 0, 0);
    chk("dir_q",    q_w[1], 32'h0000_3C00);
    chk("dir_pend", {28'd0, pend_w[1]}, 32'h0);
    cyc(1, 0, 4'b0000, 32'h0, 1, 0);
    chk("dir_commit_q",  q_w[1], 32'h0000_3C00);
    chk("dir_commit_cd", {31'd0, cd_w[1]}, 32'h0);

    // 3: last load wins; commit transfers atomically with a single pulse.
    cyc(0, 0, 4'b0001, 32'h0000_0011, 0, 0);
    cyc(0, 0, 4'b0001, 32'h0000_0022, 0, 0);
    cyc(0, 0, 4'b0100, 32'h0044_0000, 0, 0);
    chk("ld_pend", {28'd0, pend_w[0]}, 32'h5);
    chk("ld_q",    q_w[0], 32'h0);
    cyc(0, 0, 4'b0000, 32'h0, 1, 0);
    chk("cm_q",    q_w[0], 32'h0044_0022);
    chk("cm_pend", {28'd0, pend_w[0]}, 32'h0);
    chk("cm_cd",   {31'd0, cd_w[0]}, 32'h1);
    cyc(0, 0, 4'b0000, 32'h0, 0, 0);
    chk("cm_cd_drop", {31'd0, cd_w[0]}, 32'h0);

    // 4: load coincident with commit bypasses the shadow.
    cyc(0, 0, 4'b0010, 32'h0000_5500, 0, 0);
    cyc(0, 0, 4'b1000, 32'h7700_0000, 1, 0);
    chk("byp_q",    q_w[0], 32'h7744_5522);
    chk("byp_pend", {28'd0, pend_w[0]}, 32'h0);
    chk("byp_cd",   {31'd0, cd_w[0]}, 32'h1);

    // 5: abort beats commit, a coincident load survives the abort.
    cyc(0, 0, 4'b0011, 32'h0000_AABB, 0, 0);
    chk("ab_pre_pend", {28'd0, pend_w[0]}, 32'h3);
    cyc(0, 0, 4'b0100, 32'h0066_0000, 1, 1);
    chk("ab_q",    q_w[0], 32'h7744_5522);
    chk("ab_pend", {28'd0, pend_w[0]}, 32'h4);
    chk("ab_cd",   {31'd0, cd_w[0]}, 32'h0);
    cyc(0, 0, 4'b0000, 32'h0, 1, 0);
    chk("ab_cm_q", q_w[0], 32'h7766_5522);

    // 6: empty commit, then reset discarding a full set of pending loads.
    cyc(0, 0, 4'b0000, 32'h0, 0, 0);
    cyc(0, 0, 4'b0000, 32'h0, 1, 0);
    chk("empty_q",  q_w[0], 32'h7766_5522);
    chk("empty_cd", {31'd0, cd_w[0]}, 32'h0);
    cyc(0, 0, 4'b1111, 32'h0102_0304, 0, 0);
    chk("full_pend", {28'd0, pend_w[0]}, 32'hF);
    cyc(0, 1, 4'b0000, 32'h0, 0, 0);
    chk("rst2_pend", {28'd0, pend_w[0]}, 32'h0);
    cyc(0, 0, 4'b0000, 32'h0, 1, 0);
    chk("rst2_q",  q_w[0], 32'h0);
    chk("rst2_cd", {31'd0, cd_w[0]}, 32'h0);

    // A5 build: bypass commit on one channel keeps the others at RESET_VAL.
    cyc(2, 0, 4'b0001, 32'h0000_003C, 1, 0);
    chk("a5_q", q_w[2], 32'hA5A5_A53C);

    cyc(0, 0, 4'b0000, 32'h0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
